// File: rtl/sb_rx_deserializer.sv
// Sideband RX deserializer: LSB-first serial-to-parallel packet assembly with a
// one-entry pending buffer and a four-phase done/ack handshake toward the decode FSM.
module sb_rx_deserializer #(
  parameter int unsigned DATA_W = 64
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_ser_data,
  input  logic              i_ser_valid,
  input  logic              i_flush,
  input  logic              i_de_ser_done_sampled,
  output logic [DATA_W-1:0] o_deser_data,
  output logic              o_de_ser_done,
  output logic              o_frame_error,
  output logic              o_overrun
);

  localparam int unsigned CNT_W = $clog2(DATA_W);

  typedef enum logic {SH_IDLE, SH_SHIFT} sh_state_t;
  typedef enum logic [1:0] {OUT_EMPTY, OUT_FULL, OUT_WAIT_ACK_LOW} out_state_t;

  sh_state_t         sh_state, sh_next;
  out_state_t        out_state, out_next;
  logic [DATA_W-1:0] shift_q, shift_d, pend_q, word;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              pend_valid_q;
  logic              word_done, frame_err_d, overrun_d;
  logic              load_word, load_pend, store_pend, clr_pend;

  // Shift FSM: new bits enter at the MSB so bit k ends up at position k after DATA_W shifts.
  always_comb begin
    sh_next     = sh_state;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    word_done   = 1'b0;
    frame_err_d = 1'b0;
    word        = {i_ser_data, shift_q[DATA_W-1:1]};
    if (i_flush) begin
      sh_next = SH_IDLE;
      shift_d = '0;
      cnt_d   = '0;
    end else begin
      case (sh_state)
        SH_IDLE: begin
          if (i_ser_valid) begin
            shift_d = {i_ser_data, {(DATA_W-1){1'b0}}};
            cnt_d   = CNT_W'(1);
            sh_next = SH_SHIFT;
          end
        end
        SH_SHIFT: begin
          if (i_ser_valid) begin
            shift_d = word;
            if (cnt_q == CNT_W'(DATA_W-1)) begin
              word_done = 1'b1;
              cnt_d     = '0;
              sh_next   = SH_IDLE;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end else begin
            frame_err_d = 1'b1;
            cnt_d       = '0;
            sh_next     = SH_IDLE;
          end
        end
        default: sh_next = SH_IDLE;
      endcase
    end
  end

  // Output handshake; a word finishing while the ack drops goes straight to the output
  // when nothing is pending, otherwise it replaces the pending entry being unloaded.
  always_comb begin
    out_next   = out_state;
    load_word  = 1'b0;
    load_pend  = 1'b0;
    store_pend = 1'b0;
    clr_pend   = 1'b0;
    overrun_d  = 1'b0;
    if (i_flush) begin
      out_next = OUT_EMPTY;
      clr_pend = 1'b1;
    end else begin
      case (out_state)
        OUT_EMPTY: begin
          if (word_done) begin
            load_word = 1'b1;
            out_next  = OUT_FULL;
          end
        end
        OUT_FULL: begin
          if (i_de_ser_done_sampled) out_next = OUT_WAIT_ACK_LOW;
          if (word_done) begin
            if (pend_valid_q) overrun_d  = 1'b1;
            else              store_pend = 1'b1;
          end
        end
        OUT_WAIT_ACK_LOW: begin
          if (!i_de_ser_done_sampled) begin
            if (pend_valid_q) begin
              load_pend = 1'b1;
              out_next  = OUT_FULL;
              if (word_done) store_pend = 1'b1;
              else           clr_pend   = 1'b1;
            end else if (word_done) begin
              load_word = 1'b1;
              out_next  = OUT_FULL;
            end else begin
              out_next = OUT_EMPTY;
            end
          end else if (word_done) begin
            if (pend_valid_q) overrun_d  = 1'b1;
            else              store_pend = 1'b1;
          end
        end
        default: out_next = OUT_EMPTY;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sh_state      <= SH_IDLE;
      out_state     <= OUT_EMPTY;
      shift_q       <= '0;
      cnt_q         <= '0;
      pend_q        <= '0;
      pend_valid_q  <= 1'b0;
      o_deser_data  <= '0;
      o_de_ser_done <= 1'b0;
      o_frame_error <= 1'b0;
      o_overrun     <= 1'b0;
    end else begin
      sh_state      <= sh_next;
      out_state     <= out_next;
      shift_q       <= shift_d;
      cnt_q         <= cnt_d;
      o_frame_error <= frame_err_d;
      o_overrun     <= overrun_d;
      o_de_ser_done <= (out_next == OUT_FULL);
      if (load_word)      o_deser_data <= word;
      else if (load_pend) o_deser_data <= pend_q;
      if (store_pend) begin
        pend_q       <= word;
        pend_valid_q <= 1'b1;
      end else if (clr_pend) begin
        pend_valid_q <= 1'b0;
      end
    end
  end

endmodule
